ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter, the sending side of the keyboard link.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the host to the keyboard.
//  Uses the request-to-send / device-clocked frame, then checks the device ACK bit.
//  Shares the PS/2 clock/data lines with the receive path; receive is frozen while o_busy=1.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles PS/2 clock is held low before start (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles from clock release to frame end (15 ms @ 50 MHz)
// PORTS
//  clk             in   1  system clock
//  i_sclr_n        in   1  synchronous reset, active low
//  i_start         in   1  1-cycle request to send i_byte; ignored while o_busy=1
//  i_byte          in   8  command byte, captured on the accepted i_start
//  i_ps2_clk       in   1  PS/2 clock line level (raw, asynchronous)
//  i_ps2_dat       in   1  PS/2 data line level (raw, asynchronous)
//  o_ps2_clk_low   out  1  1 = drive PS/2 clock low (open-drain enable), 0 = release
//  o_ps2_dat_low   out  1  1 = drive PS/2 data low (open-drain enable), 0 = release
//  o_busy          out  1  1 from the cycle after an accepted i_start until o_done
//  o_done          out  1  1-cycle pulse at end of transaction
//  o_err           out  1  valid only with o_done: 1 = NACK or timeout, 0 = ACK received
// BEHAVIOUR
//  Reset (i_sclr_n=0 at a rising clk): state IDLE; all outputs 0; lines released.
//   Reset mid-frame aborts with no o_done. Lines are released the cycle after reset is seen.
//  Inputs: 2-FF synchronizer on i_ps2_clk and i_ps2_dat.
//   fall = synced clk was 1 last cycle and is 0 now (one pulse per falling edge).
//  Bit 0 first. parity = ~^byte (odd parity). bit counter 4b, 0..10.
//  FSM:
//   IDLE:    i_start=1 -> latch byte, compute parity -> INHIBIT (clk_low=1, busy=1 next cycle).
//   INHIBIT: hold clk_low=1 for INHIBIT_CYCLES cycles.
//            In the last inhibit cycle set dat_low=1 (start bit).
//            Next cycle clk_low=0 -> START. The timeout counter starts at 0.
//   START:   dat_low=1. On fall n (n=1..8) drive data bit n-1 (dat_low = ~bit).
//            On fall 9 drive parity. On fall 10 release data (stop bit).
//            These are counted in DATA/PARITY/STOP; the state moves on fall 1 -> DATA.
//   DATA:    on each fall: bits 0..7 are placed on successive falls. After fall 8 -> PARITY.
//   PARITY:  parity is placed on fall 9 -> STOP.
//   STOP:    on fall 10 set dat_low=0 -> ACK.
//   ACK:     on fall 11 sample synced data. 0 = ACK, 1 = NACK (err flag) -> WAIT_IDLE.
//   WAIT_IDLE: when synced clk=1 and dat=1 -> IDLE; o_done=1, o_err=flag, busy=0 same cycle.
//  Data changes only in the cycle right after a detected fall. The device samples on rising edges.
//  Timeout: counts every cycle in START..WAIT_IDLE.
//   On reaching TIMEOUT_CYCLES-1: release both lines, o_done=1, o_err=1 -> IDLE.
//  If timeout and normal completion fall in the same cycle, normal completion wins.
//  An i_start in the same cycle as o_done is ignored; a new i_start is accepted from the next cycle.
//  Glitches on clock while INHIBIT drives it low are ignored; falls are not counted outside START..ACK.
// TESTING
//  (use INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, device model clocks every 40 cycles)
//  1 Send 0xED, device ACKs.
//    Expect: clk_low held 20 cycles, then 8 bits 1,0,1,1,0,1,1,1, parity 1, stop, then o_done=1 with o_err=0.
//  2 Send 0xF4.
//    Expect: parity bit 0 on fall 9; the bench-decoded frame equals 0xF4; o_err=0.
//  3 Device leaves data high on the ACK clock -> o_done=1, o_err=1.
//  4 Device never clocks after release -> o_done=1, o_err=1 exactly 2000 cycles after clk_low falls to 0.
//    Both line outputs are 0.
//  5 Pulse i_start again while busy with a different byte.
//    Expect: that request is ignored; the frame carries the first byte; o_busy stays 1.
//  6 Assert i_sclr_n=0 after fall 5.
//    Expect: both line outputs 0 and o_busy 0 next cycle; no o_done. A following send of 0xFF completes with o_err=0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard using the request-to-send sequence:
// the clock is held low, the start bit is placed, then the device clocks the frame.
// Afterwards the device ACK bit is sampled and the transaction is reported on o_done/o_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_low,
  output logic       o_ps2_dat_low,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST      = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_START_BIT = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5,
    S_ACK       = 3'd6,
    S_WAIT_IDLE = 3'd7
  } state_t;

  state_t             r_state;
  logic [7:0]         r_byte;
  logic               r_parity;
  logic [3:0]         r_bit_cnt;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_nack;
  logic               r_clk_low;
  logic               r_dat_low;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               r_clk_s1;
  logic               r_clk_s2;
  logic               r_clk_prev;
  logic               r_dat_s1;
  logic               r_dat_s2;

  logic               w_fall;
  logic               w_active;
  logic               w_complete;
  logic               w_timeout;

  // Two-flop synchronizers for the raw PS/2 lines plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_dat;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // One pulse per synchronized falling edge of the PS/2 clock.
  assign w_fall     = r_clk_prev & ~r_clk_s2;
  // Device-clocked part of the transaction, where the timeout runs.
  assign w_active   = (r_state != S_IDLE) && (r_state != S_INHIBIT);
  // Bus back to idle after the ACK bit: normal completion.
  assign w_complete = (r_state == S_WAIT_IDLE) && r_clk_s2 && r_dat_s2;
  // Timeout only fires when normal completion is not happening in the same cycle.
  assign w_timeout  = w_active && (r_to_cnt == TO_LAST) && !w_complete;

  // Transaction FSM: inhibit, start bit, data/parity/stop bits, ACK check, bus idle wait.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_state   <= S_IDLE;
      r_byte    <= 8'h00;
      r_parity  <= 1'b0;
      r_bit_cnt <= 4'd0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_nack    <= 1'b0;
      r_clk_low <= 1'b0;
      r_dat_low <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_active) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // A request coinciding with o_done belongs to the finished transaction's cycle.
          if (i_start && !r_done) begin
            r_byte    <= i_byte;
            r_parity  <= ~^i_byte;
            r_inh_cnt <= '0;
            r_bit_cnt <= 4'd0;
            r_nack    <= 1'b0;
            r_clk_low <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          if (r_inh_cnt == INH_START_BIT) begin
            r_dat_low <= 1'b1;
          end
          if (r_inh_cnt == INH_LAST) begin
            r_clk_low <= 1'b0;
            r_dat_low <= 1'b1;
            r_to_cnt  <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_fall) begin
            r_dat_low <= ~r_byte[0];
            r_bit_cnt <= 4'd1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_dat_low <= ~r_byte[r_bit_cnt[2:0]];
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              r_state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_dat_low <= ~r_parity;
            r_bit_cnt <= 4'd9;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_dat_low <= 1'b0;
            r_bit_cnt <= 4'd10;
            r_state   <= S_ACK;
          end
        end
        S_ACK: begin
          if (w_fall) begin
            r_nack  <= r_dat_s2;
            r_state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (w_complete) begin
            r_done  <= 1'b1;
            r_err   <= r_nack;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_clk_low <= 1'b0;
          r_dat_low <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
      if (w_timeout) begin
        r_clk_low <= 1'b0;
        r_dat_low <= 1'b0;
        r_done    <= 1'b1;
        r_err     <= 1'b1;
        r_busy    <= 1'b0;
        r_state   <= S_IDLE;
      end
    end
  end

  assign o_ps2_clk_low = r_clk_low;
  assign o_ps2_dat_low = r_dat_low;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard model clocks each frame,
// decodes the bits it samples on rising edges and answers with ACK, NACK or silence.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       i_sclr_n;
  logic       i_start;
  logic [7:0] i_byte;
  logic       w_ps2_clk;
  logic       w_ps2_dat;
  logic       o_ps2_clk_low;
  logic       o_ps2_dat_low;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic       dev_clk_low;
  logic       dev_dat_low;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Open-drain bus: a line is low when either side pulls it.
  assign w_ps2_clk = ~(o_ps2_clk_low | dev_clk_low);
  assign w_ps2_dat = ~(o_ps2_dat_low | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk          (clk),
    .i_sclr_n     (i_sclr_n),
    .i_start      (i_start),
    .i_byte       (i_byte),
    .i_ps2_clk    (w_ps2_clk),
    .i_ps2_dat    (w_ps2_dat),
    .o_ps2_clk_low(o_ps2_clk_low),
    .o_ps2_dat_low(o_ps2_dat_low),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // Passive monitor sampling on the falling clk edge: event timestamps and counts.
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   clk_low_rise = 0;
  int   clk_low_fall = 0;
  int   busy_total = 0;
  int   start_cyc = 0;
  logic done_err = 1'b0;
  logic done_clk_low = 1'b0;
  logic done_dat_low = 1'b0;
  logic dat_at_release = 1'b0;
  logic prev_clk_low = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_ps2_clk_low === 1'b1 && !prev_clk_low) clk_low_rise = cyc;
    if (o_ps2_clk_low === 1'b0 && prev_clk_low) begin
      clk_low_fall   = cyc;
      dat_at_release = o_ps2_dat_low;
    end
    if (o_done === 1'b1) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      done_err     = o_err;
      done_clk_low = o_ps2_clk_low;
      done_dat_low = o_ps2_dat_low;
    end
    if (o_busy === 1'b1) busy_total = busy_total + 1;
    if (i_start === 1'b1) start_cyc = cyc;
    prev_clk_low = (o_ps2_clk_low === 1'b1);
  end

  // Reference model: odd parity bit = 1 when the byte holds an even number of ones.
  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_send(input logic [7:0] b);
    i_byte  = b;
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  // Keyboard model. mode 0 = ACK, 1 = NACK, 2 = never clocks.
  // stop_fall > 0 returns with the clock still held low after that falling edge.
  task automatic dev_frame(input int mode, input int stop_fall,
                           output logic [9:0] rx, output bit rel_ok);
    rel_ok = 1'b0;
    rx     = 10'h000;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (o_ps2_clk_low === 1'b0 && o_ps2_dat_low === 1'b1) begin
        rel_ok = 1'b1;
        break;
      end
    end
    if (!rel_ok || mode == 2) return;
    tick(10);
    for (int n = 1; n <= 11; n++) begin
      dev_clk_low = 1'b1;
      tick(20);
      if (n == stop_fall) return;
      if (n <= 10) rx[n-1] = w_ps2_dat;
      dev_clk_low = 1'b0;
      tick(10);
      if (n == 10) dev_dat_low = (mode == 0);
      tick(10);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int snap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt != snap) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int mode, input int second_at,
                           input logic [7:0] b2, output logic [9:0] rx,
                           output bit rel_ok, output bit done_ok, output int s);
    int snap;
    snap = done_cnt;
    do_send(b);
    s = start_cyc;
    if (second_at > 0) begin
      tick(second_at);
      do_send(b2);
    end
    dev_frame(mode, 0, rx, rel_ok);
    wait_done((mode == 2) ? 2500 : 300, snap, done_ok);
    tick(2);
  endtask

  task automatic test_reset;
    i_sclr_n = 1'b0;
    tick(5);
    n_total++; if (o_ps2_clk_low !== 1'b0) $display("FAIL reset_clk_low: got %b want 0", o_ps2_clk_low); else n_pass++;
    n_total++; if (o_ps2_dat_low !== 1'b0) $display("FAIL reset_dat_low: got %b want 0", o_ps2_dat_low); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else n_pass++;
    n_total++; if (o_err !== 1'b0) $display("FAIL reset_err: got %b want 0", o_err); else n_pass++;
    i_sclr_n = 1'b1;
    tick(3);
  endtask

  task automatic test_send_ed;
    logic [9:0] rx; bit rel_ok, done_ok; int s, snap, b0;
    snap = done_cnt; b0 = busy_total;
    run_frame(8'hED, 0, 0, 8'h00, rx, rel_ok, done_ok, s);
    n_total++; if (clk_low_rise !== s + 1) $display("FAIL ed_inhibit_start: got %0d want %0d", clk_low_rise, s + 1); else n_pass++;
    n_total++; if (clk_low_fall - clk_low_rise !== 20) $display("FAIL ed_inhibit_len: got %0d want 20", clk_low_fall - clk_low_rise); else n_pass++;
    n_total++; if (dat_at_release !== 1'b1) $display("FAIL ed_start_bit: got %b want 1", dat_at_release); else n_pass++;
    n_total++; if (!rel_ok) $display("FAIL ed_release: got 0 want 1"); else n_pass++;
    n_total++; if (rx[7:0] !== 8'hED) $display("FAIL ed_data: got %h want ed", rx[7:0]); else n_pass++;
    n_total++; if (rx[8] !== ref_parity(8'hED)) $display("FAIL ed_parity: got %b want %b", rx[8], ref_parity(8'hED)); else n_pass++;
    n_total++; if (rx[9] !== 1'b1) $display("FAIL ed_stop: got %b want 1", rx[9]); else n_pass++;
    n_total++; if (!done_ok || done_cnt - snap !== 1) $display("FAIL ed_done_count: got %0d want 1", done_cnt - snap); else n_pass++;
    n_total++; if (done_err !== 1'b0) $display("FAIL ed_err: got %b want 0", done_err); else n_pass++;
    n_total++; if (busy_total - b0 !== done_cyc - s - 1) $display("FAIL ed_busy_span: got %0d want %0d", busy_total - b0, done_cyc - s - 1); else n_pass++;
  endtask

  task automatic test_send_f4;
    logic [9:0] rx; bit rel_ok, done_ok; int s;
    run_frame(8'hF4, 0, 0, 8'h00, rx, rel_ok, done_ok, s);
    n_total++; if (rx[8] !== 1'b0) $display("FAIL f4_parity: got %b want 0", rx[8]); else n_pass++;
    n_total++; if (rx[7:0] !== 8'hF4) $display("FAIL f4_data: got %h want f4", rx[7:0]); else n_pass++;
    n_total++; if (!done_ok || done_err !== 1'b0) $display("FAIL f4_done_err: got done=%b err=%b want done=1 err=0", done_ok, done_err); else n_pass++;
  endtask

  task automatic test_nack;
    logic [9:0] rx; bit rel_ok, done_ok; int s; logic [7:0] b;
    b = 8'($urandom);
    run_frame(b, 1, 0, 8'h00, rx, rel_ok, done_ok, s);
    n_total++; if (rx[7:0] !== b) $display("FAIL nack_data: got %h want %h", rx[7:0], b); else n_pass++;
    n_total++; if (!done_ok || done_err !== 1'b1) $display("FAIL nack_err: got done=%b err=%b want done=1 err=1", done_ok, done_err); else n_pass++;
  endtask

  task automatic test_timeout;
    logic [9:0] rx; bit rel_ok, done_ok; int s;
    run_frame(8'($urandom), 2, 0, 8'h00, rx, rel_ok, done_ok, s);
    n_total++; if (!done_ok) $display("FAIL timeout_done: got 0 want 1"); else n_pass++;
    n_total++; if (done_cyc - clk_low_fall !== 2000) $display("FAIL timeout_latency: got %0d want 2000", done_cyc - clk_low_fall); else n_pass++;
    n_total++; if (done_err !== 1'b1) $display("FAIL timeout_err: got %b want 1", done_err); else n_pass++;
    n_total++; if (done_clk_low !== 1'b0 || done_dat_low !== 1'b0) $display("FAIL timeout_lines: got %b%b want 00", done_clk_low, done_dat_low); else n_pass++;
  endtask

  task automatic test_start_while_busy;
    logic [9:0] rx; bit rel_ok, done_ok; int s, snap, b0; logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = b1 ^ 8'h5A;
    snap = done_cnt; b0 = busy_total;
    run_frame(b1, 0, 5, b2, rx, rel_ok, done_ok, s);
    n_total++; if (rx[7:0] !== b1) $display("FAIL busy_ignore_data: got %h want %h", rx[7:0], b1); else n_pass++;
    n_total++; if (done_cnt - snap !== 1) $display("FAIL busy_ignore_done_count: got %0d want 1", done_cnt - snap); else n_pass++;
    n_total++; if (busy_total - b0 !== done_cyc - s - 1) $display("FAIL busy_ignore_span: got %0d want %0d", busy_total - b0, done_cyc - s - 1); else n_pass++;
    n_total++; if (done_err !== 1'b0) $display("FAIL busy_ignore_err: got %b want 0", done_err); else n_pass++;
  endtask

  task automatic test_midframe_reset;
    logic [9:0] rx; bit rel_ok, done_ok; int s, snap;
    snap = done_cnt;
    do_send(8'($urandom));
    dev_frame(0, 5, rx, rel_ok);
    i_sclr_n = 1'b0;
    tick(1);
    n_total++; if (o_ps2_clk_low !== 1'b0 || o_ps2_dat_low !== 1'b0) $display("FAIL mid_reset_lines: got %b%b want 00", o_ps2_clk_low, o_ps2_dat_low); else n_pass++;
    n_total++; if (o_busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", o_busy); else n_pass++;
    i_sclr_n = 1'b1;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    tick(100);
    n_total++; if (done_cnt - snap !== 0) $display("FAIL mid_reset_no_done: got %0d want 0", done_cnt - snap); else n_pass++;
    run_frame(8'hFF, 0, 0, 8'h00, rx, rel_ok, done_ok, s);
    n_total++; if (rx[7:0] !== 8'hFF || rx[8] !== ref_parity(8'hFF)) $display("FAIL mid_reset_resend_frame: got %h/%b want ff/%b", rx[7:0], rx[8], ref_parity(8'hFF)); else n_pass++;
    n_total++; if (!done_ok || done_err !== 1'b0) $display("FAIL mid_reset_resend_err: got done=%b err=%b want done=1 err=0", done_ok, done_err); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] rx; bit rel_ok, done_ok, hit; int s; logic [7:0] b;
    b = 8'($urandom);
    hit = 1'b0;
    do_send(b);
    dev_frame(0, 0, rx, rel_ok);
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (o_done === 1'b1) begin
        i_byte  = ~b;
        i_start = 1'b1;
        hit     = 1'b1;
        break;
      end
    end
    tick(1);
    i_start = 1'b0;
    tick(5);
    n_total++; if (!hit) $display("FAIL b2b_done_seen: got 0 want 1"); else n_pass++;
    n_total++; if (o_busy !== 1'b0 || o_ps2_clk_low !== 1'b0) $display("FAIL b2b_start_on_done_ignored: got busy=%b clk_low=%b want 0 0", o_busy, o_ps2_clk_low); else n_pass++;
    b = 8'($urandom);
    run_frame(b, 0, 0, 8'h00, rx, rel_ok, done_ok, s);
    n_total++; if (rx[7:0] !== b || !done_ok || done_err !== 1'b0) $display("FAIL b2b_next_frame: got %h done=%b err=%b want %h 1 0", rx[7:0], done_ok, done_err, b); else n_pass++;
  endtask

  task automatic test_random;
    logic [9:0] rx; bit rel_ok, done_ok; int s, mode; logic [7:0] b;
    for (int k = 0; k < 5; k++) begin
      b    = 8'($urandom);
      mode = int'($urandom_range(0, 1));
      run_frame(b, mode, 0, 8'h00, rx, rel_ok, done_ok, s);
      n_total++; if (rx[7:0] !== b) $display("FAIL rand_data: got %h want %h", rx[7:0], b); else n_pass++;
      n_total++; if (rx[8] !== ref_parity(b) || rx[9] !== 1'b1) $display("FAIL rand_parity_stop: got %b%b want %b1", rx[8], rx[9], ref_parity(b)); else n_pass++;
      n_total++; if (!done_ok || done_err !== (mode == 1)) $display("FAIL rand_err: got done=%b err=%b want done=1 err=%b", done_ok, done_err, (mode == 1)); else n_pass++;
    end
  endtask

  initial begin
    i_sclr_n    = 1'b0;
    i_start     = 1'b0;
    i_byte      = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    test_reset();
    test_send_ed();
    test_send_f4();
    test_nack();
    test_timeout();
    test_start_while_busy();
    test_midframe_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
